gf26_log: RTL

//  Discrete logarithm in GF(2^6): finds k in 0..62 with alpha^k == value.

---
 rtl/gf26_log.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gf26_log.sv
// Iterative discrete log in GF(2^6), one multiply-by-alpha step per clock.
// Optional GF26_LOG_BIDIR_EN adds a backward (alpha^-1) search to halve latency.
module gf26_log #(
    parameter logic [5:0] POLY_LOW = 6'h03
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [5:0] value,
    output logic [5:0] log_out,
    output logic       error_flag,
    output logic       ready_flag
);

    typedef enum logic {IDLE, SEARCH} state_t;

`ifdef GF26_LOG_BIDIR_EN
    localparam logic [5:0] K_LAST = 6'd31;
`else
    localparam logic [5:0] K_LAST = 6'd62;
`endif

    state_t     state_q, state_d;
    logic [5:0] acc_q, acc_d;
    logic [5:0] k_q, k_d;
    logic [5:0] tgt_q, tgt_d;
    logic [5:0] log_q, log_d;
    logic       rdy_q, rdy_d;
    logic       err_q, err_d;
    logic       hit_f;
    logic       hit_b;

    function automatic logic [5:0] mul_alpha(input logic [5:0] v);
        return {v[4:0], 1'b0} ^ (v[5] ? POLY_LOW : 6'h00);
    endfunction

`ifdef GF26_LOG_BIDIR_EN
    logic [5:0] accb_q, accb_d;

    function automatic logic [5:0] mul_alpha_inv(input logic [5:0] v);
        return v[0] ? ({1'b0, v[5:1]} ^ {1'b1, POLY_LOW[5:1]})
                    : {1'b0, v[5:1]};
    endfunction

    assign hit_b = (accb_q == tgt_q);
`else
    assign hit_b = 1'b0;
`endif

    assign hit_f = (acc_q == tgt_q);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (value == 6'h00) ? IDLE : SEARCH;
        end else if (state_q == SEARCH) begin
            if (hit_f || hit_b || k_q == K_LAST) state_d = IDLE;
        end
    end

    always_comb begin
        acc_d = acc_q;
        k_d   = k_q;
        tgt_d = tgt_q;
        log_d = log_q;
        rdy_d = rdy_q;
        err_d = err_q;
`ifdef GF26_LOG_BIDIR_EN
        accb_d = accb_q;
`endif
        if (start) begin
            rdy_d = 1'b0;
            err_d = 1'b0;
            tgt_d = value;
            acc_d = 6'h01;
            k_d   = 6'd0;
`ifdef GF26_LOG_BIDIR_EN
            accb_d = 6'h01;
`endif
            if (value == 6'h00) begin
                log_d = 6'd0;
                err_d = 1'b1;
                rdy_d = 1'b1;
            end
        end else if (state_q == SEARCH) begin
            if (hit_f) begin
                log_d = k_q;
                rdy_d = 1'b1;
            end else if (hit_b) begin
                log_d = 6'd63 - k_q;
                rdy_d = 1'b1;
            end else if (k_q == K_LAST) begin
                // Unreachable for a primitive polynomial
                log_d = 6'd0;
                err_d = 1'b1;
                rdy_d = 1'b1;
            end else begin
                acc_d = mul_alpha(acc_q);
                k_d   = k_q + 6'd1;
`ifdef GF26_LOG_BIDIR_EN
                accb_d = mul_alpha_inv(accb_q);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q <= 6'h00;
            k_q   <= 6'd0;
            tgt_q <= 6'h00;
            log_q <= 6'd0;
            rdy_q <= 1'b0;
            err_q <= 1'b0;
`ifdef GF26_LOG_BIDIR_EN
            accb_q <= 6'h00;
`endif
        end else begin
            acc_q <= acc_d;
            k_q   <= k_d;
            tgt_q <= tgt_d;
            log_q <= log_d;
            rdy_q <= rdy_d;
            err_q <= err_d;
`ifdef GF26_LOG_BIDIR_EN
            accb_q <= accb_d;
`endif
        end
    end

    assign log_out    = log_q;
    assign ready_flag = rdy_q;
    assign error_flag = err_q;

endmodule
